// File: rtl/abr_be_ram_arb.sv
// Two-requester round-robin arbiter for a 1R1W byte-enable RAM, with a zeroize sweep.
// Optional same-address write-to-read forwarding under ABR_RAM_ARB_BYPASS_EN.
module abr_be_ram_arb #(
   parameter int DEPTH        = 64,
   parameter int DATA_WIDTH   = 32,
   parameter int STROBE_WIDTH = 8,
   localparam int NUM_COL     = DATA_WIDTH / STROBE_WIDTH,
   localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                zeroize_i,
   output logic                                busy_o,
   input  logic [1:0]                          wr_req_i,
   output logic [1:0]                          wr_gnt_o,
   input  logic [1:0][NUM_COL-1:0]             wr_strobe_i,
   input  logic [1:0][ADDR_WIDTH-1:0]          wr_addr_i,
   input  logic [1:0][DATA_WIDTH-1:0]          wr_data_i,
   input  logic [1:0]                          rd_req_i,
   output logic [1:0]                          rd_gnt_o,
   input  logic [1:0][ADDR_WIDTH-1:0]          rd_addr_i,
   output logic [1:0]                          rd_valid_o,
   output logic [DATA_WIDTH-1:0]               rd_data_o,
   output logic                                ram_we_o,
   output logic [NUM_COL-1:0]                  ram_wstrobe_o,
   output logic [ADDR_WIDTH-1:0]               ram_waddr_o,
   output logic [DATA_WIDTH-1:0]               ram_wdata_o,
   output logic                                ram_re_o,
   output logic [ADDR_WIDTH-1:0]               ram_raddr_o,
   input  logic [DATA_WIDTH-1:0]               ram_rdata_i
);

   typedef enum logic {IDLE, CLEAR} state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    busy_q;
   logic                    wr_ptr_q, rd_ptr_q;
   logic [1:0]              wr_gnt, rd_gnt;
   logic [1:0]              rd_vld_q;
   logic [DATA_WIDTH-1:0]   rd_hold_q;
   logic [DATA_WIDTH-1:0]   rd_merge;

   // Tie goes to the pointer side; a lone requester simply wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
      if (&req) return ptr ? 2'b10 : 2'b01;
      return req;
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wr_gnt        = '0;
      rd_gnt        = '0;
      ram_we_o      = 1'b0;
      ram_wstrobe_o = '0;
      ram_waddr_o   = '0;
      ram_wdata_o   = '0;
      ram_re_o      = 1'b0;
      ram_raddr_o   = '0;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               wr_gnt = rr_pick(wr_req_i, wr_ptr_q);
               rd_gnt = rr_pick(rd_req_i, rd_ptr_q);
               if (|wr_gnt) begin
                  ram_we_o      = 1'b1;
                  ram_wstrobe_o = wr_strobe_i[wr_gnt[1]];
                  ram_waddr_o   = wr_addr_i[wr_gnt[1]];
                  ram_wdata_o   = wr_data_i[wr_gnt[1]];
               end
               if (|rd_gnt) begin
                  ram_re_o    = 1'b1;
                  ram_raddr_o = rd_addr_i[rd_gnt[1]];
               end
               if (zeroize_i) begin
                  state_d = CLEAR;
                  cnt_d   = '0;
               end
            end
            CLEAR: begin
               ram_we_o      = 1'b1;
               ram_wstrobe_o = '1;
               ram_waddr_o   = cnt_q;
               if (zeroize_i) begin
                  cnt_d = '0;
               end else if (cnt_q == LAST_ADDR) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         rd_vld_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= (state_d == CLEAR);
         rd_vld_q <= rd_gnt;
         // Pointer moves to the side that was not granted.
         if (|wr_gnt) wr_ptr_q <= wr_gnt[0];
         if (|rd_gnt) rd_ptr_q <= rd_gnt[0];
      end
   end

`ifdef ABR_RAM_ARB_BYPASS_EN
   logic                  byp_vld_q;
   logic [NUM_COL-1:0]    byp_strb_q;
   logic [DATA_WIDTH-1:0] byp_data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byp_vld_q  <= 1'b0;
         byp_strb_q <= '0;
         byp_data_q <= '0;
      end else begin
         byp_vld_q  <= (|wr_gnt) && (|rd_gnt) && (ram_waddr_o == ram_raddr_o);
         byp_strb_q <= ram_wstrobe_o;
         byp_data_q <= ram_wdata_o;
      end
   end

   for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
      assign rd_merge[c*STROBE_WIDTH +: STROBE_WIDTH] = (byp_vld_q && byp_strb_q[c]) ?
             byp_data_q[c*STROBE_WIDTH +: STROBE_WIDTH] : ram_rdata_i[c*STROBE_WIDTH +: STROBE_WIDTH];
   end
`else
   assign rd_merge = ram_rdata_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i)          rd_hold_q <= '0;
      else if (|rd_vld_q) rd_hold_q <= rd_merge;
   end

   assign rd_data_o  = (|rd_vld_q) ? rd_merge : rd_hold_q;
   assign rd_valid_o = rd_vld_q;
   assign busy_o     = busy_q;
   assign wr_gnt_o   = wr_gnt;
   assign rd_gnt_o   = rd_gnt;

endmodule
